// File: rtl/counter_cmd_pkg.sv
// Shared types and byte constants for the counter command sequencer.
package counter_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SEND
  } state_e;

  localparam logic [7:0] CMD_CLEAR  = 8'h63;
  localparam logic [7:0] CMD_RUN    = 8'h72;
  localparam logic [7:0] CMD_MODE   = 8'h6D;
  localparam logic [7:0] CMD_STATUS = 8'h73;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic int unsigned pow10(input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/counter_cmd_sequencer_if.sv
// RX/TX FIFO handshake between the sequencer (master) and the UART FIFO layer (slave).
interface counter_cmd_sequencer_if;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_data;

  modport master (
    input  rx_empty, rx_data, tx_full,
    output rx_pop, tx_push, tx_data
  );

  modport slave (
    output rx_empty, rx_data, tx_full,
    input  rx_pop, tx_push, tx_data
  );
endinterface

// File: rtl/counter_bcd_conv.sv
// Sequential binary-to-decimal converter: repeated subtraction of decreasing powers of ten.
// digits[0] is the most significant digit; done is a one-cycle pulse.
module counter_bcd_conv
  import counter_cmd_pkg::*;
#(
  parameter int unsigned CNT_W      = 14,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CNT_W-1:0]            value,
  output logic                        done,
  output logic [NUM_DIGITS-1:0][3:0]  digits
);

  localparam int unsigned K_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic             busy;
  logic [CNT_W-1:0] rem;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] weight;

  always_comb weight = CNT_W'(pow10(NUM_DIGITS - 1 - 32'(k)));

  // Once every higher weight is exhausted the remainder is the units digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      rem    <= '0;
      k      <= '0;
      digits <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy   <= 1'b1;
          rem    <= value;
          k      <= '0;
          digits <= '0;
        end
      end else if (k == K_W'(NUM_DIGITS - 1)) begin
        digits[k] <= rem[3:0];
        busy      <= 1'b0;
        done      <= 1'b1;
      end else if (rem >= weight) begin
        rem       <= rem - weight;
        digits[k] <= digits[k] + 4'd1;
      end else begin
        k <= k + K_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Merges RX command bytes with button pulses into counter controls and
// answers 's' with the saturated counter value as ASCII digits plus CR LF.
module counter_cmd_sequencer
  import counter_cmd_pkg::*;
#(
  parameter int unsigned CNT_W      = 14,
  parameter int unsigned MAX_VAL    = 9999,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn_clear,
  input  logic                          btn_run,
  input  logic                          btn_mode,
  input  logic [CNT_W-1:0]              counter,
  counter_cmd_sequencer_if.master       fifo,
  output logic                          o_stop,
  output logic                          o_mode,
  output logic                          o_clear,
  output logic                          o_busy
);

  localparam int unsigned SEQ_LEN = NUM_DIGITS + 2;
  localparam int unsigned IDX_W   = $clog2(SEQ_LEN);
  localparam int unsigned DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e                       state;
  logic [IDX_W-1:0]             idx;
  logic [NUM_DIGITS-1:0][3:0]   digits_q;
  logic [NUM_DIGITS-1:0][3:0]   conv_digits;
  logic                         conv_done;
  logic                         pop;
  logic                         cmd_clear, cmd_run, cmd_mode, cmd_status;
  logic [CNT_W-1:0]             snap_value;
  logic [7:0]                   next_byte;

  // Show-ahead RX: the head byte is decoded in the cycle it is popped.
  assign pop         = (state == IDLE) && !fifo.rx_empty;
  assign fifo.rx_pop = pop;
  assign cmd_clear   = pop && (fifo.rx_data == CMD_CLEAR);
  assign cmd_run     = pop && (fifo.rx_data == CMD_RUN);
  assign cmd_mode    = pop && (fifo.rx_data == CMD_MODE);
  assign cmd_status  = pop && (fifo.rx_data == CMD_STATUS);
  assign snap_value  = (counter > CNT_W'(MAX_VAL)) ? CNT_W'(MAX_VAL) : counter;

  counter_bcd_conv #(
    .CNT_W      (CNT_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (cmd_status),
    .value  (snap_value),
    .done   (conv_done),
    .digits (conv_digits)
  );

  always_comb begin
    next_byte = ASCII_LF;
    if (32'(idx) < NUM_DIGITS)
      next_byte = ASCII_ZERO | {4'h0, digits_q[idx[DIG_W-1:0]]};
    else if (32'(idx) == NUM_DIGITS)
      next_byte = ASCII_CR;
  end

  // Controls are serviced in every state; a button and a command on the same
  // toggle cancel, and coincident clears merge into one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      digits_q     <= '0;
      o_stop       <= 1'b0;
      o_mode       <= 1'b0;
      o_clear      <= 1'b0;
      o_busy       <= 1'b0;
      fifo.tx_push <= 1'b0;
      fifo.tx_data <= '0;
    end else begin
      o_clear      <= btn_clear | cmd_clear;
      o_stop       <= o_stop ^ btn_run ^ cmd_run;
      o_mode       <= o_mode ^ btn_mode ^ cmd_mode;
      fifo.tx_push <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_status) begin
            o_busy <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          if (conv_done) begin
            digits_q <= conv_digits;
            idx      <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (!fifo.tx_full) begin
            fifo.tx_push <= 1'b1;
            fifo.tx_data <= next_byte;
            if (idx == IDX_W'(SEQ_LEN - 1)) begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Scoreboard bench for counter_cmd_sequencer: stimulus queues expected TX bytes,
// a negedge monitor pops and compares each pushed byte.
module tb_counter_cmd_sequencer;
  import counter_cmd_pkg::*;

  logic        clk;
  logic        rst;
  logic        btn_clear, btn_run, btn_mode;
  logic [13:0] counter;
  logic        o_stop, o_mode, o_clear, o_busy;

  counter_cmd_sequencer_if ifc ();

  counter_cmd_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .btn_clear (btn_clear),
    .btn_run   (btn_run),
    .btn_mode  (btn_mode),
    .counter   (counter),
    .fifo      (ifc),
    .o_stop    (o_stop),
    .o_mode    (o_mode),
    .o_clear   (o_clear),
    .o_busy    (o_busy)
  );

  int   checks = 0;
  int   errors = 0;
  int   push_cnt = 0;
  int   clr_cnt = 0;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic full_q = 1'b0;
  bit   pop_now;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rx_update();
    ifc.rx_empty = (rxq.size() == 0);
    ifc.rx_data  = (rxq.size() == 0) ? 8'h00 : rxq[0];
  endtask

  task automatic push_rx(input logic [7:0] b);
    rxq.push_back(b);
    rx_update();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_report(input string s);
    for (int i = 0; i < 4; i++) expq.push_back(s[i]);
    expq.push_back(ASCII_CR);
    expq.push_back(ASCII_LF);
  endtask

  // Wait (bounded) until the scoreboard holds at most n outstanding bytes.
  task automatic wait_sb(input int n, input string name);
    int cyc;
    cyc = 0;
    while (expq.size() > n && cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    chk(name, 32'(expq.size() <= n), 32'd1);
  endtask

  // RX FIFO model: consume the head after the edge that popped it.
  always @(posedge clk) begin
    pop_now = ifc.rx_pop;
    #1;
    if (pop_now && rxq.size() > 0) void'(rxq.pop_front());
    rx_update();
  end

  always @(posedge clk) full_q <= ifc.tx_full;

  always @(negedge clk) begin
    if (o_clear) clr_cnt++;
    if (ifc.tx_push) begin
      push_cnt++;
      chk("tx_push_while_full", 32'(full_q), 32'd0);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got byte %0h expected no push (t=%0t)", ifc.tx_data, $time);
      end else begin
        chk("tx_byte", 32'(ifc.tx_data), 32'(expq.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int c0, p0;
    clk = 1'b0; rst = 1'b1;
    btn_clear = 1'b0; btn_run = 1'b0; btn_mode = 1'b0;
    counter = '0;
    ifc.tx_full = 1'b0;
    rx_update();
    tick(3);
    rst = 1'b0;
    tick(1);

    // Leave o_stop set so the reset check below is meaningful
    btn_run = 1'b1; tick(1); btn_run = 1'b0;
    chk("stop_pre_reset", 32'(o_stop), 32'd1);

    rst = 1'b1; tick(2);
    chk("rst_stop", 32'(o_stop), 32'd0);
    chk("rst_mode", 32'(o_mode), 32'd0);
    chk("rst_clear", 32'(o_clear), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_push", 32'(ifc.tx_push), 32'd0);
    chk("rst_txdata", 32'(ifc.tx_data), 32'd0);
    rst = 1'b0;
    c0 = clr_cnt; p0 = push_cnt;
    tick(20);
    chk("idle_no_clear", 32'(clr_cnt - c0), 32'd0);
    chk("idle_no_push", 32'(push_cnt - p0), 32'd0);
    chk("idle_stop", 32'(o_stop), 32'd0);

    // 'r' then 'm' back to back
    push_rx(CMD_RUN); push_rx(CMD_MODE);
    tick(1);
    chk("r_stop", 32'(o_stop), 32'd1);
    chk("r_mode_unchanged", 32'(o_mode), 32'd0);
    chk("m_pop_next", 32'(ifc.rx_pop), 32'd1);
    tick(1);
    chk("m_mode", 32'(o_mode), 32'd1);
    chk("m_pop_done", 32'(ifc.rx_pop), 32'd0);

    c0 = clr_cnt;
    push_rx(CMD_CLEAR);
    tick(1); chk("c_clear_hi", 32'(o_clear), 32'd1);
    tick(1); chk("c_clear_lo", 32'(o_clear), 32'd0);
    chk("c_one_pulse", 32'(clr_cnt - c0), 32'd1);

    // Status 1234; the live counter changes after the snapshot
    counter = 14'd1234;
    expect_report("1234");
    push_rx(CMD_STATUS);
    tick(1);
    chk("s_busy", 32'(o_busy), 32'd1);
    counter = 14'd0;
    wait_sb(0, "rep_1234_done");
    tick(2);
    chk("s_busy_clear", 32'(o_busy), 32'd0);

    // Status 5678 with TX full for 10 cycles mid-report
    counter = 14'd5678;
    expect_report("5678");
    push_rx(CMD_STATUS);
    wait_sb(4, "rep_5678_two");
    @(negedge clk); ifc.tx_full = 1'b1;
    @(posedge clk); p0 = push_cnt;
    tick(10);
    chk("full_no_push", 32'(push_cnt - p0), 32'd0);
    chk("full_busy", 32'(o_busy), 32'd1);
    ifc.tx_full = 1'b0;
    wait_sb(0, "rep_5678_done");
    tick(3);

    // Button and command toggles on the same control cancel
    push_rx(CMD_RUN); btn_run = 1'b1;
    tick(1); btn_run = 1'b0;
    chk("run_cancel", 32'(o_stop), 32'd1);
    btn_run = 1'b1; btn_mode = 1'b1;
    tick(1); btn_run = 1'b0; btn_mode = 1'b0;
    chk("two_btn_stop", 32'(o_stop), 32'd0);
    chk("two_btn_mode", 32'(o_mode), 32'd0);

    c0 = clr_cnt;
    push_rx(CMD_CLEAR); btn_clear = 1'b1;
    tick(1); btn_clear = 1'b0;
    chk("dual_clear_hi", 32'(o_clear), 32'd1);
    tick(1);
    chk("dual_clear_lo", 32'(o_clear), 32'd0);
    chk("dual_clear_one", 32'(clr_cnt - c0), 32'd1);

    // btn_clear during SEND keeps the original snapshot
    counter = 14'd42;
    expect_report("0042");
    push_rx(CMD_STATUS);
    tick(1);
    counter = 14'd9000;
    wait_sb(5, "rep_42_first");
    @(negedge clk); btn_clear = 1'b1;
    tick(1); btn_clear = 1'b0;
    chk("send_clear", 32'(o_clear), 32'd1);
    wait_sb(0, "rep_42_done");
    tick(2);

    // Unknown byte is consumed with no effect
    c0 = clr_cnt; p0 = push_cnt;
    push_rx(8'h41);
    tick(3);
    chk("junk_stop", 32'(o_stop), 32'd0);
    chk("junk_mode", 32'(o_mode), 32'd0);
    chk("junk_busy", 32'(o_busy), 32'd0);
    chk("junk_popped", 32'(rxq.size()), 32'd0);
    chk("junk_no_push", 32'(push_cnt - p0), 32'd0);
    chk("junk_no_clear", 32'(clr_cnt - c0), 32'd0);

    // Saturation above MAX_VAL and the all-zero value
    counter = 14'd12000;
    expect_report("9999");
    push_rx(CMD_STATUS);
    wait_sb(0, "rep_sat_done");
    tick(2);
    counter = 14'd0;
    expect_report("0000");
    push_rx(CMD_STATUS);
    wait_sb(0, "rep_zero_done");
    tick(2);

    btn_run = 1'b1; btn_mode = 1'b1;
    tick(1); btn_run = 1'b0; btn_mode = 1'b0;
    chk("pre_abort_stop", 32'(o_stop), 32'd1);

    // Reset after two of six report bytes abandons the report
    counter = 14'd3456;
    expect_report("3456");
    push_rx(CMD_STATUS);
    wait_sb(5, "abort_first");
    @(negedge clk); ifc.tx_full = 1'b1;
    tick(2);
    chk("abort_partial", 32'(expq.size()), 32'd4);
    rst = 1'b1; ifc.tx_full = 1'b0;
    expq.delete();
    p0 = push_cnt;
    tick(1);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_push", 32'(ifc.tx_push), 32'd0);
    chk("abort_stop", 32'(o_stop), 32'd0);
    chk("abort_mode", 32'(o_mode), 32'd0);
    chk("abort_txdata", 32'(ifc.tx_data), 32'd0);
    rst = 1'b0;
    tick(40);
    chk("abort_no_more", 32'(push_cnt - p0), 32'd0);

    counter = 14'd7;
    expect_report("0007");
    push_rx(CMD_STATUS);
    wait_sb(0, "rep_7_done");
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
